// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execute stage: operation and branch-condition
// encodings, the execute FSM state, and a small shift-op classifier.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_SCOMP = 4'b1000,
        OP_LUI   = 4'b1001,
        OP_SLL   = 4'b1010,
        OP_SRL   = 4'b1011,
        OP_SRA   = 4'b1100,
        OP_AND   = 4'b1101,
        OP_OR    = 4'b1110,
        OP_XOR   = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_LT   = 2'b10,
        BR_LTU  = 2'b11
    } branch_ctl_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Shifter for the ALU execute stage.
// Default build: pure combinational barrel shifter, FSM pinned at IDLE.
// With ALU_EXEC_ITER_SHIFT_EN defined: iterative shifter that moves
// SHIFT_STEP bits per cycle (fewer on the final step) through IDLE->SHIFT->IDLE.
module alu_exec_shifter
    import alu_exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     start_i,
    input  alu_op_t                  op_i,
    input  logic [XLEN-1:0]          a_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    output logic [XLEN-1:0]          result_o,       // single-cycle result
    output logic                     done_o,         // iterative shift finishing this cycle
    output logic [XLEN-1:0]          done_result_o,  // value to register when done_o
    output exec_state_t              state_o
);

    localparam int SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] do_shift(input alu_op_t op,
                                                 input logic [XLEN-1:0] v,
                                                 input logic [SHW-1:0] amt);
        case (op)
            OP_SLL:  return v << amt;
            OP_SRL:  return v >> amt;
            OP_SRA:  return $signed(v) >>> amt;
            default: return v;
        endcase
    endfunction

`ifdef ALU_EXEC_ITER_SHIFT_EN

    localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

    exec_state_t     state_q;
    logic [XLEN-1:0] val_q;
    logic [SHW-1:0]  rem_q;
    alu_op_t         op_q;

    logic            last_step;
    logic [SHW-1:0]  step_amt;
    logic [XLEN-1:0] step_val;

    // Amount shifted this cycle: a full step, or whatever remains on the last one.
    always_comb begin
        last_step = (rem_q <= STEP);
        step_amt  = last_step ? rem_q : STEP;
        step_val  = do_shift(op_q, val_q, step_amt);
    end

    // Shift FSM: a non-zero shift amount enters SHIFT; flush aborts without output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (shamt_i != '0)) begin
                        state_q <= SHIFT;
                        val_q   <= a_i;
                        rem_q   <= shamt_i;
                        op_q    <= op_i;
                    end
                end
                SHIFT: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        val_q <= step_val;
                        rem_q <= rem_q - step_amt;
                        if (last_step) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A zero shift amount completes in the accept cycle and returns the operand.
    assign result_o      = a_i;
    assign done_o        = (state_q == SHIFT) && last_step && !flush_i;
    assign done_result_o = step_val;
    assign state_o       = state_q;

`else

    logic unused_shifter_inputs;

    assign result_o      = do_shift(op_i, a_i, shamt_i);
    assign done_o        = 1'b0;
    assign done_result_o = '0;
    assign state_o       = IDLE;
    assign unused_shifter_inputs = ^{clk, rst, flush_i, start_i};

`endif

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: captures a decoded op, computes the ALU result and the
// branch decision, registers them for the memory stage, and pulses a PC
// redirect for taken branches.
// Optional feature macro: ALU_EXEC_ITER_SHIFT_EN (iterative shifter).
//
// Handshake: an input transfer happens on in_valid & in_ready and an output
// transfer on out_valid & out_ready; a valid output holds stable until it is
// accepted, and in_ready never depends on in_valid.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic            neg,
    input  logic [1:0]      branch_control,
    input  logic            is_branch,
    input  logic            shift2,
    input  logic            shift6,
    input  logic            lw_add,
    input  logic            beq_imm,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] cmp_imm,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_offset,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_is_load,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int SHW = $clog2(XLEN);

    alu_op_t         op;
    logic [XLEN-1:0] opnd_b;
    logic [XLEN-1:0] cmp_b;
    logic            cmp;
    logic            cmp_out;
    logic            taken;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            shift_deferred;

    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic            out_is_load_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic [XLEN-1:0] shift_res;
    logic            shift_done;
    logic [XLEN-1:0] shift_done_res;
    exec_state_t     state;

    alu_exec_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .start_i       (accept && is_shift_op(op)),
        .op_i          (op),
        .a_i           (src_a),
        .shamt_i       (opnd_b[SHW-1:0]),
        .result_o      (shift_res),
        .done_o        (shift_done),
        .done_result_o (shift_done_res),
        .state_o       (state)
    );

    // Operand B pre-shift, compare operand select, condition and ALU result.
    always_comb begin
        op = alu_op_t'(alu_control);

        if (shift2) begin
            opnd_b = src_b << 2;
        end else if (shift6) begin
            opnd_b = src_b << 6;
        end else begin
            opnd_b = src_b;
        end

        cmp_b = beq_imm ? cmp_imm : opnd_b;

        case (branch_ctl_t'(branch_control))
            BR_EQ:   cmp = (src_a == cmp_b);
            BR_LT:   cmp = ($signed(src_a) < $signed(cmp_b));
            BR_LTU:  cmp = (src_a < cmp_b);
            default: cmp = 1'b0;
        endcase

        cmp_out = cmp ^ neg;
        taken   = is_branch && cmp_out;

        case (op)
            OP_ADD:   alu_res = src_a + opnd_b;
            OP_SUB:   alu_res = src_a - opnd_b;
            OP_SCOMP: alu_res = {{(XLEN-1){1'b0}}, cmp_out};
            OP_LUI:   alu_res = opnd_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:   alu_res = shift_res;
            OP_AND:   alu_res = src_a & opnd_b;
            OP_OR:    alu_res = src_a | opnd_b;
            OP_XOR:   alu_res = src_a ^ opnd_b;
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_ITER_SHIFT_EN
    assign shift_deferred = is_shift_op(op) && (opnd_b[SHW-1:0] != '0);
`else
    assign shift_deferred = 1'b0;
`endif

    assign in_ready = (!out_valid_q || out_ready) && (state == IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Output and redirect registers; flush wins over everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_is_load_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= accept && taken;
            if (accept && taken) begin
                redirect_pc_q <= pc + br_offset;
            end

            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q   <= !shift_deferred;
                out_result_q  <= alu_res;
                out_is_load_q <= lw_add;
            end else if (shift_done) begin
                out_valid_q  <= 1'b1;
                out_result_q <= shift_done_res;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_is_load    = out_is_load_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: vector table, hand-written corner sequences,
// a randomized phase, and a scoreboard queue checked at the output handshake.
module tb_alu_exec_stage;

    localparam int XLEN = 32;
    localparam int W    = XLEN + 1;

`ifdef ALU_EXEC_ITER_SHIFT_EN
    localparam int EXP_SRA_LAT = 9;
    localparam int EXP_SRA_BLK = 8;
`else
    localparam int EXP_SRA_LAT = 1;
    localparam int EXP_SRA_BLK = 0;
`endif

    typedef struct {
        logic [3:0]      ctl;
        logic            neg;
        logic [1:0]      bc;
        logic            isb;
        logic            s2;
        logic            s6;
        logic            lw;
        logic            bi;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] off;
        logic [XLEN-1:0] res;
        logic            tk;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic            neg;
    logic [1:0]      branch_control;
    logic            is_branch;
    logic            shift2;
    logic            shift6;
    logic            lw_add;
    logic            beq_imm;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] cmp_imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] br_offset;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_is_load;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            man_ready;
    logic            rnd_ready;
    logic            rand_ready;

    int              checks = 0;
    int              fails  = 0;
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    mon_e;
    vec_t            vt[24];

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    alu_exec_stage #(.XLEN(XLEN), .SHIFT_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_control    (alu_control),
        .neg            (neg),
        .branch_control (branch_control),
        .is_branch      (is_branch),
        .shift2         (shift2),
        .shift6         (shift6),
        .lw_add         (lw_add),
        .beq_imm        (beq_imm),
        .src_a          (src_a),
        .src_b          (src_b),
        .cmp_imm        (cmp_imm),
        .pc             (pc),
        .br_offset      (br_offset),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_is_load    (out_is_load),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "time limit");
    end

    // Random backpressure source, used only while rand_ready is set
    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each output transfer against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: got %h required no output", out_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_result", out_result, mon_e[XLEN-1:0]);
                check("out_is_load", {31'b0, out_is_load}, {31'b0, mon_e[XLEN]});
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] ctl, input logic ng, input logic [1:0] bc,
                                input logic isb, input logic s2, input logic s6, input logic lw,
                                input logic bi, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [XLEN-1:0] imm, input logic [XLEN-1:0] p,
                                input logic [XLEN-1:0] off, input logic [XLEN-1:0] res, input logic tk);
        vec_t v;
        v.ctl = ctl; v.neg = ng; v.bc = bc; v.isb = isb; v.s2 = s2; v.s6 = s6; v.lw = lw;
        v.bi = bi; v.a = a; v.b = b; v.imm = imm; v.pc = p; v.off = off; v.res = res; v.tk = tk;
        return v;
    endfunction

    // Reference model for randomized ops
    function automatic vec_t model(input vec_t v);
        vec_t            r;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] a2;
        logic            c;
        r  = v;
        b  = v.s2 ? (v.b << 2) : (v.s6 ? (v.b << 6) : v.b);
        a2 = v.bi ? v.imm : b;
        case (v.bc)
            2'd1:    c = (v.a == a2);
            2'd2:    c = ($signed(v.a) < $signed(a2));
            2'd3:    c = (v.a < a2);
            default: c = 1'b0;
        endcase
        c = c ^ v.neg;
        case (v.ctl)
            4'h0:    r.res = v.a + b;
            4'h1:    r.res = v.a - b;
            4'h8:    r.res = {31'b0, c};
            4'h9:    r.res = b;
            4'hA:    r.res = v.a << b[4:0];
            4'hB:    r.res = v.a >> b[4:0];
            4'hC:    r.res = $signed(v.a) >>> b[4:0];
            4'hD:    r.res = v.a & b;
            4'hE:    r.res = v.a | b;
            4'hF:    r.res = v.a ^ b;
            default: r.res = '0;
        endcase
        r.tk = v.isb & c;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        alu_control    = v.ctl;
        neg            = v.neg;
        branch_control = v.bc;
        is_branch      = v.isb;
        shift2         = v.s2;
        shift6         = v.s6;
        lw_add         = v.lw;
        beq_imm        = v.bi;
        src_a          = v.a;
        src_b          = v.b;
        cmp_imm        = v.imm;
        pc             = v.pc;
        br_offset      = v.off;
    endtask

    // Present one op, wait for acceptance, queue its result, check the redirect
    task automatic send(input vec_t v);
        int n;
        drive(v);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back({v.lw, v.res});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("redirect_valid", {31'b0, redirect_valid}, {31'b0, v.tk});
        if (v.tk) check("redirect_pc", redirect_pc, v.pc + v.off);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Main sequence
    initial begin
        logic [3:0] ops[10];
        vec_t       v;
        time        t0;
        int         lat;
        int         blk;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; man_ready = 1'b1; rand_ready = 1'b0;
        drive(mk(4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_is_load", {31'b0, out_is_load}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //            ctl   ng bc   isb s2 s6 lw bi a             b             imm  pc          off           res           tk
        vt[0]  = mk(4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h7FFFFFFF, 32'h1,        0,   0,          0,            32'h80000000, 0);
        vt[1]  = mk(4'h0, 0, 2'd0, 0, 1, 0, 0, 0, 32'h7FFFFFFF, 32'h3,        0,   0,          0,            32'h8000000B, 0);
        vt[2]  = mk(4'h0, 0, 2'd0, 0, 0, 1, 0, 0, 32'h10,       32'h1,        0,   0,          0,            32'h50,       0);
        vt[3]  = mk(4'h0, 0, 2'd0, 0, 1, 1, 0, 0, 32'h0,        32'h1,        0,   0,          0,            32'h4,        0);
        vt[4]  = mk(4'h1, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0,        32'h1,        0,   0,          0,            32'hFFFFFFFF, 0);
        vt[5]  = mk(4'h9, 0, 2'd0, 0, 0, 0, 0, 0, 32'hDEAD,     32'h12345000, 0,   0,          0,            32'h12345000, 0);
        vt[6]  = mk(4'hA, 0, 2'd0, 0, 0, 0, 0, 0, 32'h1,        32'd31,       0,   0,          0,            32'h80000000, 0);
        vt[7]  = mk(4'hB, 0, 2'd0, 0, 0, 0, 0, 0, 32'h80000000, 32'd31,       0,   0,          0,            32'h1,        0);
        vt[8]  = mk(4'hC, 0, 2'd0, 0, 0, 0, 0, 0, 32'h80000000, 32'd31,       0,   0,          0,            32'hFFFFFFFF, 0);
        vt[9]  = mk(4'hC, 0, 2'd0, 0, 0, 0, 0, 0, 32'h80000000, 32'h24,       0,   0,          0,            32'hF8000000, 0);
        vt[10] = mk(4'hD, 0, 2'd0, 0, 0, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0,   0,          0,            32'hF000F000, 0);
        vt[11] = mk(4'hE, 0, 2'd0, 0, 0, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0,   0,          0,            32'hFFF0FFF0, 0);
        vt[12] = mk(4'hF, 0, 2'd0, 0, 0, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0,   0,          0,            32'h0FF00FF0, 0);
        vt[13] = mk(4'h8, 1, 2'd2, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        0,   32'h100,    32'h20,       32'h0,        0);
        vt[14] = mk(4'h8, 0, 2'd2, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        0,   32'h100,    32'h20,       32'h1,        1);
        vt[15] = mk(4'h8, 0, 2'd3, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        0,   0,          0,            32'h0,        0);
        vt[16] = mk(4'h8, 1, 2'd0, 1, 0, 0, 0, 0, 32'h5,        32'h5,        0,   32'h200,    32'hFFFFFFF0, 32'h1,        1);
        vt[17] = mk(4'h0, 0, 2'd0, 0, 0, 0, 1, 0, 32'h1000,     32'h20,       0,   0,          0,            32'h1020,     0);
        vt[18] = mk(4'h8, 0, 2'd1, 1, 0, 0, 0, 1, 32'h5,        32'h9,        5,   32'h400,    32'h10,       32'h1,        1);
        vt[19] = mk(4'hA, 0, 2'd0, 0, 1, 0, 0, 0, 32'h1,        32'h1,        0,   0,          0,            32'h10,       0);
        vt[20] = mk(4'hB, 0, 2'd0, 0, 0, 0, 0, 0, 32'hABCD,     32'h0,        0,   0,          0,            32'hABCD,     0);
        vt[21] = mk(4'h2, 0, 2'd0, 0, 0, 0, 0, 0, 32'h5,        32'h6,        0,   0,          0,            32'h0,        0);
        vt[22] = mk(4'h0, 0, 2'd1, 1, 0, 0, 0, 0, 32'h4,        32'h4,        0,   32'h10,     32'h10,       32'h8,        1);
        vt[23] = mk(4'h8, 0, 2'd2, 0, 0, 1, 0, 0, 32'h40,       32'h2,        0,   0,          0,            32'h1,        0);

        // Back-to-back throughput on the single-cycle ops, then the rest of the table
        t0 = $time;
        for (int i = 0; i < 6; i++) send(vt[i]);
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd6);
        for (int i = 6; i < 24; i++) send(vt[i]);
        drain();

        // SRA latency and input blocking
        send(mk(4'hC, 0, 2'd0, 0, 0, 0, 0, 0, 32'h80000000, 32'd31, 0, 0, 0, 32'hFFFFFFFF, 0));
        lat = 1;
        blk = 0;
        while (!out_valid && lat < 30) begin
            if (!in_ready) blk++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("sra_latency", lat, EXP_SRA_LAT);
        check("sra_in_ready_low", blk, EXP_SRA_BLK);
        drain();

        // Taken branch under backpressure: single redirect pulse, stable output
        man_ready = 1'b0;
        send(mk(4'h8, 0, 2'd1, 1, 0, 0, 0, 1, 32'h5, 32'h9, 32'h5, 32'h100, 32'h40, 32'h1, 1));
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_out_result", out_result, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            if (i > 0) check("bp_redirect_pulse", {31'b0, redirect_valid}, 32'd0);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        man_ready = 1'b1;
        drain();

        // Flush with a pending output and a same-cycle taken branch
        man_ready = 1'b0;
        send(mk(4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h1, 32'h2, 0, 0, 0, 32'h3, 0));
        drive(mk(4'h8, 0, 2'd1, 1, 0, 0, 0, 0, 32'h7, 32'h7, 0, 32'h80, 32'h8, 32'h1, 1));
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_no_redirect", {31'b0, redirect_valid}, 32'd0);
        man_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush_op_lost", {31'b0, out_valid}, 32'd0);

        // Flush in the cycle a redirect is already showing does not retract it
        send(mk(4'h8, 0, 2'd3, 1, 0, 0, 0, 0, 32'h1, 32'h2, 0, 32'h300, 32'h8, 32'h1, 1));
        flush = 1'b1;
        #1;
        check("flush_keeps_redirect", {31'b0, redirect_valid}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("redirect_after_flush", {31'b0, redirect_valid}, 32'd0);
        check("out_valid_after_flush", {31'b0, out_valid}, 32'd0);
        drain();

        // Asynchronous reset with a pending output and an active redirect
        man_ready = 1'b0;
        send(mk(4'h8, 0, 2'd1, 1, 0, 0, 0, 0, 32'h3, 32'h3, 0, 32'h40, 32'h4, 32'h1, 1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("arst_out_result", out_result, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        man_ready = 1'b1;
        send(mk(4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 32'd10, 32'd20, 0, 0, 0, 32'd30, 0));
        drain();

`ifdef ALU_EXEC_ITER_SHIFT_EN
        // Reset while shifting, then flush while shifting
        send(mk(4'hA, 0, 2'd0, 0, 0, 0, 0, 0, 32'h1, 32'd31, 0, 0, 0, 32'h80000000, 0));
        #2;
        rst = 1'b1;
        #1;
        check("arst_shift_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_shift_out_valid", {31'b0, out_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(mk(4'hB, 0, 2'd0, 0, 0, 0, 0, 0, 32'hF0000000, 32'd20, 0, 0, 0, 32'h00000F00, 0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            check("shift_flush_no_output", {31'b0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("shift_flush_idle", {31'b0, in_ready}, 32'd1);
        send(mk(4'hB, 0, 2'd0, 0, 0, 0, 0, 0, 32'hF0000000, 32'd20, 0, 0, 0, 32'h00000F00, 0));
        drain();
`endif

        // Randomized ops with random backpressure
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h8; ops[3] = 4'h9; ops[4] = 4'hA;
        ops[5] = 4'hB; ops[6] = 4'hC; ops[7] = 4'hD; ops[8] = 4'hE; ops[9] = 4'hF;
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int sel;
            v.ctl = ops[$urandom_range(0, 9)];
            v.neg = 1'($urandom_range(0, 1));
            v.bc  = 2'($urandom_range(0, 3));
            v.isb = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 2);
            v.s2  = (sel == 1);
            v.s6  = (sel == 2);
            v.lw  = 1'($urandom_range(0, 1));
            v.bi  = 1'($urandom_range(0, 1));
            v.a   = $urandom;
            v.b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            v.imm = ($urandom_range(0, 1) == 1) ? v.a : $urandom;
            v.pc  = $urandom;
            v.off = $urandom;
            send(model(v));
        end
        rand_ready = 1'b0;
        man_ready  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
